// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: first-word-fall-through, occupancy, overrun flag and drop counter.
// Define UART_RX_FIFO_WATERMARK_EN to add the registered almost_full_o output.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned AF_LEVEL   = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  wr_stb_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o,
    input  logic                  clr_ovf_i,
    output logic [7:0]            drop_cnt_o
`ifdef UART_RX_FIFO_WATERMARK_EN
    ,
    output logic                  almost_full_o
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = DEPTH[DEPTH_LOG2:0];

    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_af_level_bad
        $error("uart_rx_fifo: AF_LEVEL out of range");
    end

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            drop_q, drop_d;
    logic                  empty_s, full_s, wr_acc_s, rd_acc_s, drop_s;

    assign empty_s = (count_q == {(DEPTH_LOG2+1){1'b0}});
    assign full_s  = (count_q == DEPTH_C);
    // A read on a full FIFO frees the slot the simultaneous write needs.
    assign rd_acc_s = rd_en_i & ~empty_s;
    assign wr_acc_s = wr_stb_i & (~full_s | rd_en_i);
    assign drop_s   = wr_stb_i & full_s & ~rd_en_i;

    // Next-state for pointers, occupancy and overrun bookkeeping.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear wins and restarts the count at one.
        if (drop_s) begin
            ovf_d = 1'b1;
            if (clr_ovf_i) begin
                drop_d = 8'd1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end else begin
                drop_d = drop_q;
            end
        end else if (clr_ovf_i) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end else begin
            ovf_d  = ovf_q;
            drop_d = drop_q;
        end
    end

    // State registers with synchronous reset; buffered data is discarded by clearing the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= {DEPTH_LOG2{1'b0}};
            wr_ptr_q <= {DEPTH_LOG2{1'b0}};
            count_q  <= {(DEPTH_LOG2+1){1'b0}};
            ovf_q    <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Storage array; contents deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc_s && !rst_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o  = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
    assign empty_o    = empty_s;
    assign full_o     = full_s;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign drop_cnt_o = drop_q;

`ifdef UART_RX_FIFO_WATERMARK_EN
    localparam logic [DEPTH_LOG2:0] AF_C = AF_LEVEL[DEPTH_LOG2:0];
    logic af_q;

    // Watermark tracks the count that the same edge loads into count_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            af_q <= 1'b0;
        end else begin
            af_q <= (count_d >= AF_C);
        end
    end

    assign almost_full_o = af_q;
`endif

endmodule
